// File: rtl/acq_stream_router.sv
// Acquisition front-end: synchronises the ADC chip-select and start button, then fans
// selected source channels (or an internal ramp) out to NOUT lock-step, block-framed streams.
module acq_stream_router #(
  parameter int NCH      = 4,
  parameter int NOUT     = 2,
  parameter int DW       = 16,
  parameter int BLOCK    = 256,
  parameter int DEB_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_start,
  input  logic                 cs_in,
  input  logic [NCH*DW-1:0]    ch_data,
  input  logic                 cfg_valid,
  input  logic [NOUT*8-1:0]    cfg_sel,
  input  logic [NOUT-1:0]      fifo_full,
  output logic [NOUT*DW-1:0]   out_data,
  output logic [NOUT-1:0]      out_wr,
  output logic                 out_sof,
  output logic                 running,
  output logic [15:0]          drop_cnt
);
  localparam int IW = $clog2(BLOCK);
  localparam logic [DEB_BITS-1:0] LOCK_LEN = DEB_BITS'(1) << (DEB_BITS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  b_s1_q, b_s2_q, b_s3_q, press_q, press_d;
  logic [DEB_BITS-1:0]   lock_q, lock_d;
  logic                  cs_f_q, cs_ff_q, stb_q, stb_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         ramp_q, ramp_d;
  logic [15:0]           drop_q, drop_d;
  logic [NOUT*8-1:0]     sel_q, sel_d, pend_q, pend_d, sel_use;
  logic                  pend_flag_q, pend_flag_d;
  logic [NOUT*DW-1:0]    out_data_q, out_data_d;
  logic [NOUT-1:0]       out_wr_q, out_wr_d;
  logic                  out_sof_q, out_sof_d, running_q, running_d;
  logic                  qstb, wr, any_full, idx_zero, idx_last, bnd_load;
  logic [7:0]            src;

  assign any_full = |fifo_full;
  assign qstb     = stb_q & (state_q != S_IDLE);
  assign wr       = qstb & ~any_full;
  assign idx_zero = (idx_q == '0);
  assign idx_last = (idx_q == IW'(BLOCK - 1));
  // Pending selection lands on the first write of a block, or whenever idle
  assign bnd_load = pend_flag_q & ((wr & idx_zero) | (state_q == S_IDLE));
  assign sel_use  = bnd_load ? pend_q : sel_q;

  always_comb begin
    press_d     = b_s2_q & ~b_s3_q & (lock_q == '0);
    lock_d      = press_d ? LOCK_LEN : ((lock_q != '0) ? lock_q - DEB_BITS'(1) : lock_q);
    stb_d       = cs_f_q & ~cs_ff_q;
    idx_d       = wr ? idx_q + IW'(1) : idx_q;
    ramp_d      = qstb ? ramp_q + DW'(1) : ramp_q;
    drop_d      = (qstb & any_full & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    sel_d       = sel_use;
    pend_d      = cfg_valid ? cfg_sel : pend_q;
    pend_flag_d = cfg_valid | (pend_flag_q & ~bnd_load);
    out_wr_d    = {NOUT{wr}};
    out_sof_d   = wr & idx_zero;
    out_data_d  = out_data_q;
    running_d   = (state_q != S_IDLE);
    src         = '0;
    if (wr) begin
      for (int k = 0; k < NOUT; k++) begin
        src = sel_use[k*8 +: 8];
        if (int'(src) < NCH) out_data_d[k*DW +: DW] = ch_data[int'(src)*DW +: DW];
        else                 out_data_d[k*DW +: DW] = ramp_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (press_q) state_d = S_RUN;
      S_RUN: begin
        // A press that lands on a block boundary stops at once; otherwise finish the block
        if (press_q) begin
          if ((idx_zero & ~wr) | (wr & idx_last)) state_d = S_IDLE;
          else                                    state_d = S_STOP;
        end
      end
      S_STOP: if (wr & idx_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      b_s1_q      <= 1'b0;
      b_s2_q      <= 1'b0;
      b_s3_q      <= 1'b0;
      press_q     <= 1'b0;
      lock_q      <= '0;
      cs_f_q      <= 1'b0;
      cs_ff_q     <= 1'b0;
      stb_q       <= 1'b0;
      idx_q       <= '0;
      ramp_q      <= '0;
      drop_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      out_data_q  <= '0;
      out_wr_q    <= '0;
      out_sof_q   <= 1'b0;
      running_q   <= 1'b0;
      for (int k = 0; k < NOUT; k++) sel_q[k*8 +: 8] <= 8'(k % NCH);
    end else begin
      state_q     <= state_d;
      b_s1_q      <= btn_start;
      b_s2_q      <= b_s1_q;
      b_s3_q      <= b_s2_q;
      press_q     <= press_d;
      lock_q      <= lock_d;
      cs_f_q      <= cs_in;
      cs_ff_q     <= cs_f_q;
      stb_q       <= stb_d;
      idx_q       <= idx_d;
      ramp_q      <= ramp_d;
      drop_q      <= drop_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      out_data_q  <= out_data_d;
      out_wr_q    <= out_wr_d;
      out_sof_q   <= out_sof_d;
      running_q   <= running_d;
    end
  end

  assign out_data = out_data_q;
  assign out_wr   = out_wr_q;
  assign out_sof  = out_sof_q;
  assign running  = running_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_acq_stream_router.sv
// Randomised bench for acq_stream_router: a block-level reference model predicts every
// write (data, sof), drop count and run state from button, strobe and config activity.
module tb_acq_stream_router;
  localparam int NCH = 4, NOUT = 2, DW = 16, BLOCK = 256, DEB_BITS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

  logic clk = 1'b0, rst = 1'b1, btn_start = 1'b0, cs_in = 1'b0, cfg_valid = 1'b0;
  logic [NCH*DW-1:0]  ch_data = '0;
  logic [NOUT*8-1:0]  cfg_sel = '0;
  logic [NOUT-1:0]    fifo_full = '0;
  logic [NOUT*DW-1:0] out_data;
  logic [NOUT-1:0]    out_wr;
  logic               out_sof, running;
  logic [15:0]        drop_cnt;

  acq_stream_router #(.NCH(NCH), .NOUT(NOUT), .DW(DW), .BLOCK(BLOCK), .DEB_BITS(DEB_BITS)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .cs_in(cs_in), .ch_data(ch_data),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .fifo_full(fifo_full), .out_data(out_data),
    .out_wr(out_wr), .out_sof(out_sof), .running(running), .drop_cnt(drop_cnt)
  );

  always #40 clk = ~clk;

  int     n_chk = 0, n_pass = 0, n_wr = 0, dut_blk = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int          m_mode, m_idx, m_drop;
  logic [DW-1:0] m_ramp;
  logic [7:0]  m_sel [NOUT];
  logic [7:0]  m_pend [NOUT];
  bit          m_pflag;
  longint      last_acc;
  logic [DW-1:0] cur_ch [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_idx = 0; m_drop = 0; m_ramp = '0; m_pflag = 0; last_acc = -100;
    for (int k = 0; k < NOUT; k++) begin m_sel[k] = 8'(k % NCH); m_pend[k] = '0; end
  endtask

  task automatic model_cfg(input logic [NOUT*8-1:0] v);
    for (int k = 0; k < NOUT; k++) m_pend[k] = v[k*8 +: 8];
    m_pflag = 1;
    if (m_mode == M_IDLE) begin m_sel = m_pend; m_pflag = 0; end
  endtask

  task automatic model_strobe(input logic [NOUT-1:0] full, output bit ew, output bit es,
                              output logic [NOUT*DW-1:0] ed);
    ew = 0; es = 0; ed = '0;
    if (m_mode != M_IDLE) begin
      if (full != '0) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        ew = 1;
        if (m_idx == 0 && m_pflag) begin m_sel = m_pend; m_pflag = 0; end
        es = (m_idx == 0);
        for (int k = 0; k < NOUT; k++) begin
          if (int'(m_sel[k]) < NCH) ed[k*DW +: DW] = cur_ch[m_sel[k]];
          else                      ed[k*DW +: DW] = m_ramp;
        end
        m_idx = (m_idx + 1) % BLOCK;
        if (m_mode == M_STOP && m_idx == 0) m_mode = M_IDLE;
      end
      m_ramp = m_ramp + 1'b1;
    end
  endtask

  task automatic press_effect(input longint t);
    if (t - last_acc >= 9) begin
      last_acc = t;
      if (m_mode == M_IDLE)     m_mode = M_RUN;
      else if (m_mode == M_RUN) m_mode = (m_idx == 0) ? M_IDLE : M_STOP;
    end
  endtask

  task automatic drive_ch(input bit rnd);
    for (int i = 0; i < NCH; i++) begin
      cur_ch[i] = rnd ? DW'($urandom) : DW'(16'h100 + i);
      ch_data[i*DW +: DW] = cur_ch[i];
    end
  endtask

  task automatic press(input int gap);
    longint t;
    btn_start = 1'b1;
    @(posedge clk); #1 t = cyc; btn_start = 1'b0;
    repeat (gap) @(posedge clk);
    #1 press_effect(t);
  endtask

  task automatic cfg(input logic [NOUT*8-1:0] v);
    cfg_valid = 1'b1; cfg_sel = v;
    @(posedge clk); #1 cfg_valid = 1'b0;
    model_cfg(v);
  endtask

  task automatic sample(input bit rnd, input logic [NOUT-1:0] full, input bit cfg_now,
                        input logic [NOUT*8-1:0] cfg_v);
    bit ew, es;
    logic [NOUT*DW-1:0] ed;
    drive_ch(rnd); fifo_full = full; cs_in = 1'b1;
    @(posedge clk); #1 cs_in = 1'b0;
    @(posedge clk); #1;
    if (cfg_now) begin cfg_valid = 1'b1; cfg_sel = cfg_v; end
    @(posedge clk); #1 cfg_valid = 1'b0;
    model_strobe(full, ew, es, ed);
    if (cfg_now) model_cfg(cfg_v);
    chk("wr", 64'(out_wr), 64'({NOUT{ew}}));
    chk("sof", 64'(out_sof), 64'(es));
    if (ew) chk("data", 64'(out_data), 64'(ed));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (out_wr[0]) begin dut_blk = out_sof ? 1 : dut_blk + 1; n_wr++; end
    fifo_full = '0;
    @(posedge clk); #1;
    chk("wr_pulse", 64'(out_wr), 64'(0));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2*BLOCK && m_idx != target; i++) sample(1, '0, 0, '0);
    chk("run_to_idx", 64'(m_idx), 64'(target));
  endtask

  task automatic cs_hold(input int cycles);
    bit ew, es, got_sof;
    logic [NOUT*DW-1:0] ed, got_d;
    int cnt;
    longint tg;
    drive_ch(1); cnt = 0; got_d = '0; got_sof = 0; tg = 0;
    cs_in = 1'b1;
    for (int i = 0; i < cycles + 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) btn_start = 1'b1;
      if (i == 1) begin btn_start = 1'b0; tg = cyc; end
      if (i == cycles - 1) cs_in = 1'b0;
      if (out_wr != '0) begin cnt++; got_d = out_data; got_sof = out_sof; end
    end
    model_strobe('0, ew, es, ed);
    press_effect(tg);
    chk("hold_writes", 64'(cnt), 64'(1));
    chk("hold_data", 64'(got_d), 64'(ed));
    chk("hold_sof", 64'(got_sof), 64'(es));
    chk("hold_running", 64'(running), 64'(m_mode != M_IDLE));
  endtask

  task automatic reset_mid();
    drive_ch(1); cs_in = 1'b1;
    @(posedge clk); #1 cs_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    chk("rst_wr", 64'(out_wr), 64'(0));
    chk("rst_sof", 64'(out_sof), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_running", 64'(running), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk); #1;
    chk("rst_nowrite", 64'(out_wr), 64'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [NOUT*8-1:0] rand_cfg();
    logic [NOUT*8-1:0] v;
    for (int k = 0; k < NOUT; k++) v[k*8 +: 8] = 8'($urandom_range(0, 5));
    return v;
  endfunction

  initial begin
    #(80 * 60000);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int blk_before;
    logic [NOUT-1:0] full;
    bit cfg_now;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_wr", 64'(out_wr), 64'(0));
    chk("init_sof", 64'(out_sof), 64'(0));
    chk("init_data", 64'(out_data), 64'(0));
    chk("init_running", 64'(running), 64'(0));
    chk("init_drop", 64'(drop_cnt), 64'(0));

    press(6);
    chk("running_after_press", 64'(running), 64'(1));
    n_wr = 0;
    repeat (300) sample(0, '0, 0, '0);
    chk("writes_300", 64'(n_wr), 64'(300));
    chk("running_300", 64'(running), 64'(1));

    run_to(100);
    cfg(16'h0702);
    run_to(20);

    blk_before = dut_blk;
    repeat (5) sample(1, 2'b10, 0, '0);
    chk("drop_5", 64'(drop_cnt), 64'(5));
    sample(1, '0, 0, '0);
    chk("idx_continue", 64'(dut_blk), 64'(blk_before + 1));

    for (int i = 0; i < 300; i++) begin
      full = ($urandom_range(0, 7) == 0) ? NOUT'($urandom_range(1, 3)) : '0;
      if ($urandom_range(0, 29) == 0) cfg(rand_cfg());
      cfg_now = (m_idx == 0) && ($urandom_range(0, 1) == 1);
      sample(1, full, cfg_now, rand_cfg());
    end

    run_to(10);
    press(3);
    press(6);
    chk("running_stopping", 64'(running), 64'(1));
    for (int i = 0; i < BLOCK && m_mode != M_IDLE; i++) sample(1, '0, 0, '0);
    chk("stop_block_len", 64'(dut_blk), 64'(BLOCK));
    chk("running_idle", 64'(running), 64'(0));
    repeat (3) sample(1, '0, 0, '0);

    press(3);
    press(6);
    chk("lockout_ignored", 64'(running), 64'(1));
    run_to(50);
    reset_mid();
    press(4);
    cs_hold(20);
    repeat (20) sample(1, NOUT'($urandom_range(0, 1)), 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
